// File: rtl/mult_share_arbiter_pkg.sv
// Shared types for the multiplier-sharing arbiter: widths, owner ID and the
// per-stage shadow record that tracks the multiplier cell's two registers.
package mult_arb_pkg;

  localparam int W       = 32;
  localparam int NREQ    = 2;
  localparam int OWNER_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef logic [OWNER_W-1:0] owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } stage_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Bundle of requester, response and multiplier-cell signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface mult_share_arbiter_if #(
  parameter int NREQ = mult_arb_pkg::NREQ,
  parameter int W    = mult_arb_pkg::W
);

  logic [NREQ-1:0]         rq_valid;
  logic [NREQ-1:0]         rq_ready;
  logic [NREQ-1:0][W-1:0]  rq_src1;
  logic [NREQ-1:0][W-1:0]  rq_src2;
  logic [NREQ-1:0]         rq_src1_signed;
  logic [NREQ-1:0]         rq_src2_signed;

  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [2*W-1:0]          rsp_data;

  logic [W-1:0]            mul_src1;
  logic [W-1:0]            mul_src2;
  logic                    mul_src1_signed;
  logic                    mul_src2_signed;
  logic                    mul_in_en;
  logic                    mul_out_en;
  logic [2*W-1:0]          mul_result;

  logic                    busy;

  modport slave (
    input  rq_valid, rq_src1, rq_src2, rq_src1_signed, rq_src2_signed,
    input  rsp_ready, mul_result,
    output rq_ready, rsp_valid, rsp_data,
    output mul_src1, mul_src2, mul_src1_signed, mul_src2_signed,
    output mul_in_en, mul_out_en, busy
  );

  modport master (
    output rq_valid, rq_src1, rq_src2, rq_src1_signed, rq_src2_signed,
    output rsp_ready, mul_result,
    input  rq_ready, rsp_valid, rsp_data,
    input  mul_src1, mul_src2, mul_src1_signed, mul_src2_signed,
    input  mul_in_en, mul_out_en, busy
  );

endinterface

// File: rtl/mult_share_arbiter_rr_arb2.sv
// Two-way round-robin selector: ptr names the requester that wins a tie;
// produces a one-hot grant and the matching owner ID.
module rr_arb2
  import mult_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       en,
  input  owner_t     ptr,
  output logic [1:0] grant,
  output owner_t     grant_id
);

  always_comb begin
    grant = '0;
    if (en) begin
      if (&valid) grant[ptr] = 1'b1;
      else        grant      = valid;
    end
  end

  assign grant_id = grant[1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one two-stage multiplier cell between requesters; shadows the cell's
// valid/owner per stage and freezes the whole cell on response backpressure.
module mult_share_arbiter #(
  parameter int NREQ = mult_arb_pkg::NREQ,
  parameter int W    = mult_arb_pkg::W
) (
  input  logic                  clk,
  input  logic                  reset,
  mult_share_arbiter_if.slave   bus
);

  mult_arb_pkg::stage_t stg_p1, stg_p2;
  mult_arb_pkg::owner_t rr_ptr, grant_id;
  logic [1:0]           grant;
  logic                 advance, arb_en;
  logic [W-1:0]         sel_src1, sel_src2;
  logic                 sel_src1_signed, sel_src2_signed;

  // The cell can only move when its output register is empty or being drained.
  assign advance = ~stg_p2.valid | bus.rsp_ready[stg_p2.owner];
  assign arb_en  = advance & ~reset;

  rr_arb2 u_rr (
    .valid    (bus.rq_valid),
    .en       (arb_en),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.rq_ready   = grant;
  assign bus.mul_in_en  = advance;
  assign bus.mul_out_en = advance;

  // Idle operand lanes park on requester 0; the cell's capture is ignored then.
  always_comb begin
    sel_src1        = '0;
    sel_src2        = '0;
    sel_src1_signed = 1'b0;
    sel_src2_signed = 1'b0;
    if (!reset) begin
      sel_src1        = bus.rq_src1[0];
      sel_src2        = bus.rq_src2[0];
      sel_src1_signed = bus.rq_src1_signed[0];
      sel_src2_signed = bus.rq_src2_signed[0];
      if (grant[1]) begin
        sel_src1        = bus.rq_src1[1];
        sel_src2        = bus.rq_src2[1];
        sel_src1_signed = bus.rq_src1_signed[1];
        sel_src2_signed = bus.rq_src2_signed[1];
      end
    end
  end

  assign bus.mul_src1        = sel_src1;
  assign bus.mul_src2        = sel_src2;
  assign bus.mul_src1_signed = sel_src1_signed;
  assign bus.mul_src2_signed = sel_src2_signed;

  // Stage p1 shadows the cell input register, p2 its output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_p1 <= '0;
      stg_p2 <= '0;
      rr_ptr <= '0;
    end else begin
      if (advance) begin
        stg_p1.valid <= |grant;
        stg_p1.owner <= grant_id;
        stg_p2       <= stg_p1;
      end
      if (|grant) rr_ptr <= ~grant_id;
    end
  end

  // Response side: result belongs to whoever owns the output register.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NREQ; i++)
      bus.rsp_valid[i] = stg_p2.valid && (stg_p2.owner == mult_arb_pkg::owner_t'(i));
  end

  assign bus.rsp_data = bus.mul_result;
  assign bus.busy     = stg_p1.valid | stg_p2.valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural two-stage cell.
module tb_mult_share_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  mult_share_arbiter_if bus();

  mult_share_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier cell: operand register then product register.
  logic [W-1:0] c_a, c_b;
  logic         c_sa, c_sb;

  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_a <= '0; c_b <= '0; c_sa <= 1'b0; c_sb <= 1'b0;
      bus.mul_result <= '0;
    end else begin
      if (bus.mul_in_en) begin
        c_a <= bus.mul_src1; c_b <= bus.mul_src2;
        c_sa <= bus.mul_src1_signed; c_sb <= bus.mul_src2_signed;
      end
      if (bus.mul_out_en) bus.mul_result <= mul_fn(c_a, c_b, c_sa, c_sb);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb);
    bus.rq_src1[i] = a; bus.rq_src2[i] = b;
    bus.rq_src1_signed[i] = sa; bus.rq_src2_signed[i] = sb;
  endtask

  logic [1:0]  exp_rv [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [63:0] exp_d  [4] = '{64'd20, 64'd63, 64'd24, 64'd69};

  initial begin
    reset = 1'b1;
    bus.rsp_ready = 2'b11;
    bus.rq_valid  = 2'b11;
    set_req(0, 32'h1234, 32'h4321, 1'b1, 1'b1);
    set_req(1, 32'h5678, 32'h8765, 1'b1, 1'b1);

    // Reset: requests present but suppressed
    @(negedge clk);
    check("rst_rq_ready", 64'(bus.rq_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_in_en", 64'(bus.mul_in_en), 64'd1);
    check("rst_out_en", 64'(bus.mul_out_en), 64'd1);
    check("rst_src1", 64'(bus.mul_src1), 64'd0);
    check("rst_src2", 64'(bus.mul_src2), 64'd0);
    check("rst_src1_signed", 64'(bus.mul_src1_signed), 64'd0);
    next_cycle();
    reset = 1'b0;
    bus.rq_valid = 2'b00;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    // Signed -3 * 7 from req0
    next_cycle();
    set_req(0, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1);
    bus.rq_valid = 2'b01;
    @(negedge clk);
    check("a_rq_ready", 64'(bus.rq_ready), 64'd1);
    check("a_mul_src1", 64'(bus.mul_src1), 64'hFFFF_FFFD);
    check("a_mul_src1_signed", 64'(bus.mul_src1_signed), 64'd1);
    next_cycle();
    bus.rq_valid = 2'b00;
    @(negedge clk);
    check("a_t1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("a_t1_busy", 64'(bus.busy), 64'd1);

    // Response for req0 while req1 issues an unsigned max*max
    next_cycle();
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    bus.rq_valid = 2'b10;
    @(negedge clk);
    check("a_t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("a_t2_rsp_data", bus.rsp_data, 64'hFFFF_FFFF_FFFF_FFEB);
    check("b_rq_ready", 64'(bus.rq_ready), 64'd2);
    check("b_mul_src1", 64'(bus.mul_src1), 64'hFFFF_FFFF);
    next_cycle();
    bus.rq_valid = 2'b00;
    @(negedge clk);
    check("b_t1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("b_t2_rsp_valid", 64'(bus.rsp_valid), 64'd2);
    check("b_t2_rsp_data", bus.rsp_data, 64'hFFFF_FFFE_0000_0001);

    // Both requesting for four cycles: alternating grants and responses
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (k < 4) begin
        bus.rq_valid = 2'b11;
        set_req(0, 32'(10 + k), 32'd2, 1'b0, 1'b0);
        set_req(1, 32'(20 + k), 32'd3, 1'b0, 1'b0);
      end else begin
        bus.rq_valid = 2'b00;
      end
      @(negedge clk);
      if (k < 4) check($sformatf("c_grant%0d", k), 64'(bus.rq_ready), 64'(exp_rv[k]));
      if (k < 2) check($sformatf("c_rsp_valid%0d", k), 64'(bus.rsp_valid), 64'd0);
      else begin
        check($sformatf("c_rsp_valid%0d", k), 64'(bus.rsp_valid), 64'(exp_rv[k-2]));
        check($sformatf("c_rsp_data%0d", k), bus.rsp_data, exp_d[k-2]);
      end
    end

    // Backpressure on req0's result
    next_cycle();
    bus.rq_valid = 2'b01;
    set_req(0, 32'd100, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("d_grant0", 64'(bus.rq_ready), 64'd1);
    next_cycle();
    bus.rq_valid = 2'b10;
    set_req(1, 32'd7, 32'd6, 1'b0, 1'b0);
    @(negedge clk);
    check("d_grant1", 64'(bus.rq_ready), 64'd2);
    for (int j = 0; j < 3; j++) begin
      next_cycle();
      bus.rq_valid  = 2'b11;
      bus.rsp_ready = 2'b10;
      set_req(0, 32'd55, 32'd1, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("d_in_en%0d", j), 64'(bus.mul_in_en), 64'd0);
      check($sformatf("d_out_en%0d", j), 64'(bus.mul_out_en), 64'd0);
      check($sformatf("d_rq_ready%0d", j), 64'(bus.rq_ready), 64'd0);
      check($sformatf("d_rsp_valid%0d", j), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("d_rsp_data%0d", j), bus.rsp_data, 64'd300);
      check($sformatf("d_idle_src1_%0d", j), 64'(bus.mul_src1), 64'd55);
    end
    next_cycle();
    bus.rq_valid  = 2'b00;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("d_rel_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("d_rel_rsp_data", bus.rsp_data, 64'd300);
    check("d_rel_in_en", 64'(bus.mul_in_en), 64'd1);
    next_cycle();
    @(negedge clk);
    check("d_next_rsp_valid", 64'(bus.rsp_valid), 64'd2);
    check("d_next_rsp_data", bus.rsp_data, 64'd42);
    next_cycle();
    @(negedge clk);
    check("d_idle_busy", 64'(bus.busy), 64'd0);

    // Reset with both stages occupied; pointer left favouring req1
    next_cycle();
    bus.rq_valid = 2'b10;
    set_req(1, 32'd3, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("e_grant1", 64'(bus.rq_ready), 64'd2);
    next_cycle();
    bus.rq_valid = 2'b01;
    set_req(0, 32'd4, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("e_grant0", 64'(bus.rq_ready), 64'd1);
    next_cycle();
    bus.rq_valid = 2'b00;
    @(negedge clk);
    check("e_pre_busy", 64'(bus.busy), 64'd1);
    check("e_pre_rsp_valid", 64'(bus.rsp_valid), 64'd2);
    #1;
    reset = 1'b1;
    #1;
    check("e_rst_busy", 64'(bus.busy), 64'd0);
    check("e_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    reset = 1'b0;
    bus.rq_valid = 2'b11;
    set_req(0, 32'd9, 32'd9, 1'b0, 1'b0);
    set_req(1, 32'd8, 32'd8, 1'b0, 1'b0);
    @(negedge clk);
    check("e_first_grant", 64'(bus.rq_ready), 64'd1);
    check("e_no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    bus.rq_valid = 2'b00;
    @(negedge clk);
    check("e_t1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("e_t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    check("e_t2_rsp_data", bus.rsp_data, 64'd81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
